// File: rtl/kianv_mem_bridge.sv
// Routes single outstanding core requests to a RAM or MMIO target by physical address,
// with a bounded wait per access that turns a silent target into an access fault.
module kianv_mem_bridge #(
   parameter logic [33:0] RAM_BASE       = 34'h0_8000_0000,
   parameter logic [33:0] RAM_SIZE       = 34'h0_0200_0000,
   parameter logic [33:0] IO_BASE        = 34'h0_1000_0000,
   parameter logic [33:0] IO_SIZE        = 34'h0_0100_0000,
   parameter int          TIMEOUT_CYCLES = 1024
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        cpu_mem_valid,
   output logic        cpu_mem_ready,
   input  logic [3:0]  cpu_mem_wstrb,
   input  logic [33:0] cpu_mem_addr,
   input  logic [31:0] cpu_mem_wdata,
   output logic [31:0] cpu_mem_rdata,
   output logic        cpu_access_fault,
   output logic        ram_valid,
   input  logic        ram_ready,
   output logic [31:0] ram_addr,
   output logic [3:0]  ram_wstrb,
   output logic [31:0] ram_wdata,
   input  logic [31:0] ram_rdata,
   output logic        io_valid,
   input  logic        io_ready,
   output logic [31:0] io_addr,
   output logic [3:0]  io_wstrb,
   output logic [31:0] io_wdata,
   input  logic [31:0] io_rdata
);

   typedef enum logic [1:0] {IDLE, RAM, IO, RESP} state_t;

   localparam logic [34:0] RAM_END   = {1'b0, RAM_BASE} + {1'b0, RAM_SIZE};
   localparam logic [34:0] IO_END    = {1'b0, IO_BASE} + {1'b0, IO_SIZE};
   localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT_CYCLES - 1);

   state_t      state, state_nxt;
   logic        pend;
   logic [33:0] req_addr;
   logic [3:0]  req_wstrb;
   logic [31:0] req_wdata;
   logic [15:0] wait_cnt;
   logic        fault_q;
   logic [31:0] rdata_q;
   logic        hit_ram, hit_io;
   logic [33:0] ram_off, io_off;
   logic        resp_load, resp_fault;
   logic [31:0] resp_data;

   // Decode runs on the latched request, one cycle after acceptance.
   always_comb begin
      hit_ram = (req_addr[33:32] == 2'b00) && (req_addr >= RAM_BASE) && ({1'b0, req_addr} < RAM_END);
      hit_io  = (req_addr[33:32] == 2'b00) && (req_addr >= IO_BASE) && ({1'b0, req_addr} < IO_END);
      ram_off = req_addr - RAM_BASE;
      io_off  = req_addr - IO_BASE;
   end

   always_comb begin
      state_nxt  = state;
      resp_load  = 1'b0;
      resp_fault = 1'b0;
      resp_data  = 32'h0;
      case (state)
         IDLE: begin
            if (pend) begin
               if (hit_ram) begin
                  state_nxt = RAM;
               end else if (hit_io) begin
                  state_nxt = IO;
               end else begin
                  state_nxt  = RESP;
                  resp_load  = 1'b1;
                  resp_fault = 1'b1;
               end
            end
         end
         RAM: begin
            if (ram_ready) begin
               state_nxt = RESP;
               resp_load = 1'b1;
               resp_data = (req_wstrb == 4'h0) ? ram_rdata : 32'h0;
            end else if (wait_cnt == WAIT_LAST) begin
               state_nxt  = RESP;
               resp_load  = 1'b1;
               resp_fault = 1'b1;
            end
         end
         IO: begin
            if (io_ready) begin
               state_nxt = RESP;
               resp_load = 1'b1;
               resp_data = (req_wstrb == 4'h0) ? io_rdata : 32'h0;
            end else if (wait_cnt == WAIT_LAST) begin
               state_nxt  = RESP;
               resp_load  = 1'b1;
               resp_fault = 1'b1;
            end
         end
         RESP: state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         pend      <= 1'b0;
         req_addr  <= '0;
         req_wstrb <= '0;
         req_wdata <= '0;
         wait_cnt  <= '0;
         fault_q   <= 1'b0;
         rdata_q   <= '0;
         ram_addr  <= '0;
         ram_wstrb <= '0;
         ram_wdata <= '0;
         io_addr   <= '0;
         io_wstrb  <= '0;
         io_wdata  <= '0;
      end else begin
         state <= state_nxt;
         if (state == IDLE && !pend && cpu_mem_valid) begin
            req_addr  <= cpu_mem_addr;
            req_wstrb <= cpu_mem_wstrb;
            req_wdata <= cpu_mem_wdata;
            pend      <= 1'b1;
         end
         if (state == IDLE && pend) begin
            pend <= 1'b0;
            if (hit_ram) begin
               ram_addr  <= ram_off[31:0];
               ram_wstrb <= req_wstrb;
               ram_wdata <= req_wdata;
            end else if (hit_io) begin
               io_addr  <= io_off[31:0];
               io_wstrb <= req_wstrb;
               io_wdata <= req_wdata;
            end
         end
         // Only RAM/IO count; any other state leaves it cleared for the next entry.
         if (state == RAM || state == IO) begin
            wait_cnt <= wait_cnt + 16'd1;
         end else begin
            wait_cnt <= '0;
         end
         if (resp_load) begin
            rdata_q <= resp_data;
            fault_q <= resp_fault;
         end
      end
   end

   assign ram_valid        = (state == RAM);
   assign io_valid         = (state == IO);
   assign cpu_mem_ready    = (state == RESP);
   assign cpu_access_fault = (state == RESP) && fault_q;
   assign cpu_mem_rdata    = rdata_q;

endmodule

// File: tb/tb_kianv_mem_bridge.sv
// Scoreboard bench for kianv_mem_bridge: behavioural RAM/IO targets with programmable
// ready delay and stray readies, plus a reference memory model predicting every response.
module tb_kianv_mem_bridge;

   localparam int TMO = 8;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        cpu_mem_valid = 1'b0;
   logic        cpu_mem_ready;
   logic [3:0]  cpu_mem_wstrb = 4'h0;
   logic [33:0] cpu_mem_addr = '0;
   logic [31:0] cpu_mem_wdata = '0;
   logic [31:0] cpu_mem_rdata;
   logic        cpu_access_fault;
   logic        ram_valid, io_valid;
   logic        ram_ready, io_ready;
   logic [31:0] ram_addr, io_addr, ram_wdata, io_wdata, ram_rdata, io_rdata;
   logic [3:0]  ram_wstrb, io_wstrb;

   always #5 clk = ~clk;

   kianv_mem_bridge #(.TIMEOUT_CYCLES(TMO)) dut (
      .clk(clk), .reset(reset),
      .cpu_mem_valid(cpu_mem_valid), .cpu_mem_ready(cpu_mem_ready),
      .cpu_mem_wstrb(cpu_mem_wstrb), .cpu_mem_addr(cpu_mem_addr),
      .cpu_mem_wdata(cpu_mem_wdata), .cpu_mem_rdata(cpu_mem_rdata),
      .cpu_access_fault(cpu_access_fault),
      .ram_valid(ram_valid), .ram_ready(ram_ready), .ram_addr(ram_addr),
      .ram_wstrb(ram_wstrb), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
      .io_valid(io_valid), .io_ready(io_ready), .io_addr(io_addr),
      .io_wstrb(io_wstrb), .io_wdata(io_wdata), .io_rdata(io_rdata)
   );

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h", tag, got, exp);
      end
   endtask

   typedef struct packed {
      logic [31:0] data;
      logic        fault;
   } exp_t;
   exp_t sb_q[$];

   logic [31:0] slv_ram[16], slv_io[16], ref_ram[16], ref_io[16];
   int          ram_delay = 0, io_delay = 0;
   int          ram_vcycles = 0, io_vcycles = 0;
   logic [31:0] last_ram_addr = '0, last_ram_wdata = '0, last_io_addr = '0, last_io_wdata = '0;
   logic [3:0]  last_ram_wstrb = '0, last_io_wstrb = '0;

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                         input logic [3:0] st);
      logic [31:0] r;
      r = old;
      for (int b = 0; b < 4; b++) if (st[b]) r[8*b +: 8] = wd[8*b +: 8];
      return r;
   endfunction

   // RAM target: ready on the (ram_delay+1)th valid cycle, random stray readies when idle.
   initial begin
      int cnt;
      cnt = 0; ram_ready = 1'b0; ram_rdata = '0;
      forever begin
         @(negedge clk);
         ram_ready = 1'b0;
         ram_rdata = $urandom;
         if (ram_valid) begin
            ram_vcycles++;
            if (cnt == ram_delay) begin
               ram_ready = 1'b1;
               last_ram_addr = ram_addr; last_ram_wdata = ram_wdata; last_ram_wstrb = ram_wstrb;
               if (ram_wstrb == 4'h0) ram_rdata = slv_ram[ram_addr[5:2]];
               else slv_ram[ram_addr[5:2]] = merge(slv_ram[ram_addr[5:2]], ram_wdata, ram_wstrb);
            end
            cnt++;
         end else begin
            cnt = 0;
            if ($urandom_range(0, 3) == 0) ram_ready = 1'b1;
         end
      end
   end

   initial begin
      int cnt;
      cnt = 0; io_ready = 1'b0; io_rdata = '0;
      forever begin
         @(negedge clk);
         io_ready = 1'b0;
         io_rdata = $urandom;
         if (io_valid) begin
            io_vcycles++;
            if (cnt == io_delay) begin
               io_ready = 1'b1;
               last_io_addr = io_addr; last_io_wdata = io_wdata; last_io_wstrb = io_wstrb;
               if (io_wstrb == 4'h0) io_rdata = slv_io[io_addr[5:2]];
               else slv_io[io_addr[5:2]] = merge(slv_io[io_addr[5:2]], io_wdata, io_wstrb);
            end
            cnt++;
         end else begin
            cnt = 0;
            if ($urandom_range(0, 3) == 0) io_ready = 1'b1;
         end
      end
   end

   // Response monitor: every ready pulse must match the oldest expectation.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         check("onehot_valid", 32'(ram_valid & io_valid), 32'h0);
         if (cpu_mem_ready) begin
            if (sb_q.size() == 0) begin
               check("spurious_ready", 32'h1, 32'h0);
            end else begin
               e = sb_q.pop_front();
               check("sb_data", cpu_mem_rdata, e.data);
               check("sb_fault", 32'(cpu_access_fault), 32'(e.fault));
            end
         end else begin
            check("fault_unqualified", 32'(cpu_access_fault), 32'h0);
         end
      end
   end

   // Issues one request starting at a point where the DUT is (or will next be) IDLE.
   // exp_lat > 0 checks the negedge count from the accepting edge to the ready pulse.
   task automatic do_req(input logic [33:0] addr, input logic [3:0] st, input logic [31:0] wd,
                         input int dly, input int exp_lat, output logic [31:0] got);
      logic        is_ram, is_io, seen;
      logic [33:0] off34;
      logic [31:0] off;
      logic [3:0]  idx;
      exp_t        e;
      int          lat, rv0, iv0, exp_rv, exp_iv;
      is_ram = (addr >= 34'h0_8000_0000) && (addr < 34'h0_8200_0000);
      is_io  = (addr >= 34'h0_1000_0000) && (addr < 34'h0_1100_0000);
      off34  = is_ram ? addr - 34'h0_8000_0000 : addr - 34'h0_1000_0000;
      off    = off34[31:0];
      idx    = off[5:2];
      e.fault = 1'b1;
      e.data  = 32'h0;
      if ((is_ram || is_io) && dly < TMO) begin
         e.fault = 1'b0;
         if (st == 4'h0) e.data = is_ram ? ref_ram[idx] : ref_io[idx];
         else if (is_ram) ref_ram[idx] = merge(ref_ram[idx], wd, st);
         else ref_io[idx] = merge(ref_io[idx], wd, st);
      end
      exp_rv = !is_ram ? 0 : (dly < TMO ? dly + 1 : TMO);
      exp_iv = !is_io  ? 0 : (dly < TMO ? dly + 1 : TMO);
      ram_delay = dly; io_delay = dly;
      rv0 = ram_vcycles; iv0 = io_vcycles;
      sb_q.push_back(e);
      cpu_mem_valid = 1'b1; cpu_mem_addr = addr; cpu_mem_wstrb = st; cpu_mem_wdata = wd;
      @(posedge clk);
      lat = 0; seen = 1'b0; got = '0;
      while (!seen && lat < 40) begin
         @(negedge clk);
         lat++;
         if (cpu_mem_ready) begin
            seen = 1'b1;
            got  = cpu_mem_rdata;
         end
      end
      check("resp_seen", 32'(seen), 32'h1);
      if (exp_lat > 0) check("latency", 32'(lat), 32'(exp_lat));
      @(posedge clk);
      #1;
      cpu_mem_valid = 1'b0; cpu_mem_addr = {2'b00, $urandom}; cpu_mem_wstrb = 4'($urandom);
      @(negedge clk);
      check("single_pulse", 32'(cpu_mem_ready), 32'h0);
      check("rdata_hold", cpu_mem_rdata, got);
      check("ram_valid_cycles", 32'(ram_vcycles - rv0), 32'(exp_rv));
      check("io_valid_cycles", 32'(io_vcycles - iv0), 32'(exp_iv));
      if (!e.fault) begin
         check("dn_addr", is_ram ? last_ram_addr : last_io_addr, off);
         if (st != 4'h0) begin
            check("dn_wdata", is_ram ? last_ram_wdata : last_io_wdata, wd);
            check("dn_wstrb", 32'(is_ram ? last_ram_wstrb : last_io_wstrb), 32'(st));
         end
      end
      if (!seen) sb_q.delete();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] got;
      logic [33:0] unmapped[5];
      logic [33:0] a;
      logic [3:0]  st;
      int          cat;
      unmapped[0] = 34'h0_0000_0000; unmapped[1] = 34'h1_8000_0010; unmapped[2] = 34'h0_8200_0000;
      unmapped[3] = 34'h0_0FFF_FFFC; unmapped[4] = 34'h0_1100_0000;
      for (int i = 0; i < 16; i++) begin
         slv_ram[i] = $urandom; ref_ram[i] = slv_ram[i];
         slv_io[i]  = $urandom; ref_io[i]  = slv_io[i];
      end

      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_ready", 32'(cpu_mem_ready), 32'h0);
      check("rst_fault", 32'(cpu_access_fault), 32'h0);
      check("rst_rdata", cpu_mem_rdata, 32'h0);
      check("rst_valids", 32'({ram_valid, io_valid}), 32'h0);
      @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);

      slv_ram[4] = 32'hDEADBEEF; ref_ram[4] = 32'hDEADBEEF;
      do_req(34'h0_8000_0010, 4'h0, 32'h0, 0, 3, got);
      check("ram_rd_data", got, 32'hDEADBEEF);
      check("ram_rd_addr", last_ram_addr, 32'h10);

      do_req(34'h0_1000_0004, 4'hF, 32'h55, 5, 8, got);
      check("io_wr_rdata", got, 32'h0);
      check("io_wr_addr", last_io_addr, 32'h4);
      check("io_wr_wdata", last_io_wdata, 32'h55);
      check("io_wr_wstrb", 32'(last_io_wstrb), 32'hF);
      do_req(34'h0_1000_0004, 4'h0, 32'h0, 0, 3, got);
      check("io_rd_back", got, 32'h55);

      do_req(34'h1_8000_0000, 4'h0, 32'h0, 0, 2, got);
      check("unmapped_hi_rdata", got, 32'h0);
      do_req(34'h0_0000_0000, 4'h0, 32'h0, 0, 2, got);
      check("unmapped_zero_rdata", got, 32'h0);
      do_req(34'h0_8200_0000, 4'h3, 32'h1234, 0, 2, got);
      do_req(34'h0_81FF_FFFC, 4'h0, 32'h0, 1, 4, got);
      do_req(34'h0_10FF_FFFF, 4'h0, 32'h0, 0, 3, got);

      do_req(34'h0_8000_0020, 4'h0, 32'h0, 100, 10, got);
      check("timeout_rdata", got, 32'h0);
      do_req(34'h0_8000_0020, 4'h0, 32'h0, 7, 10, got);
      check("late_ready_data", got, ref_ram[8]);

      ram_delay = 100;
      cpu_mem_valid = 1'b1; cpu_mem_addr = 34'h0_8000_0008; cpu_mem_wstrb = 4'h0;
      repeat (4) @(posedge clk);
      #1 reset = 1'b1;
      @(negedge clk);
      check("abort_pre_valid", 32'(ram_valid), 32'h1);
      @(posedge clk);
      #1 cpu_mem_valid = 1'b0;
      @(negedge clk);
      check("abort_valid_drop", 32'(ram_valid), 32'h0);
      check("abort_no_ready", 32'(cpu_mem_ready), 32'h0);
      @(posedge clk);
      #1 reset = 1'b0;
      repeat (3) @(negedge clk);
      do_req(34'h0_8000_0008, 4'h0, 32'h0, 0, 3, got);
      check("after_abort_data", got, ref_ram[2]);

      for (int i = 0; i < 100; i++) begin
         cat = $urandom_range(0, 9);
         if (cat < 4)      a = 34'h0_8000_0000 + 34'($urandom_range(0, 63));
         else if (cat < 8) a = 34'h0_1000_0000 + 34'($urandom_range(0, 63));
         else              a = unmapped[$urandom_range(0, 4)];
         st = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
         do_req(a, st, $urandom, $urandom_range(0, 9), -1, got);
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end

      repeat (3) @(negedge clk);
      check("sb_drained", 32'(sb_q.size()), 32'h0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
